// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller and its light monitor.
// Light encodings, phase codes, fault codes, default dwells and monitor states.
package tlc_pkg;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam logic [2:0] PH_NONE = 3'd0;
    localparam logic [2:0] PH_1    = 3'd1;
    localparam logic [2:0] PH_2    = 3'd2;
    localparam logic [2:0] PH_3    = 3'd3;
    localparam logic [2:0] PH_4    = 3'd4;
    localparam logic [2:0] PH_5    = 3'd5;
    localparam logic [2:0] PH_6    = 3'd6;

    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_ILLEGAL     = 3'd1;
    localparam logic [2:0] FC_SEQUENCE    = 3'd2;
    localparam logic [2:0] FC_SHORT_DWELL = 3'd3;
    localparam logic [2:0] FC_OVERSTAY    = 3'd4;

    localparam logic [7:0] DWELL_P1 = 8'd8;
    localparam logic [7:0] DWELL_P2 = 8'd3;
    localparam logic [7:0] DWELL_P3 = 8'd6;
    localparam logic [7:0] DWELL_P4 = 8'd6;
    localparam logic [7:0] DWELL_P5 = 8'd4;
    localparam logic [7:0] DWELL_P6 = 8'd3;

    typedef enum logic [1:0] {
        MON_SYNC  = 2'd0,
        MON_TRACK = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_e;

    // P6 wraps to P1; anything that is not a phase has no successor.
    function automatic logic [2:0] phase_succ(input logic [2:0] ph);
        logic [2:0] nxt;
        case (ph)
            PH_1, PH_2, PH_3, PH_4, PH_5: nxt = ph + 3'd1;
            PH_6:                         nxt = PH_1;
            default:                      nxt = PH_NONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tlc_phase_decode.sv
// Maps the four observed light buses back to a phase number.
// Every pattern not in the phase table, including non-one-hot buses, is 0.
module tlc_phase_decode
    import tlc_pkg::*;
(
    input  logic [2:0] m1_i,
    input  logic [2:0] m2_i,
    input  logic [2:0] mt_i,
    input  logic [2:0] s_i,
    output logic [2:0] phase_o
);

    logic [11:0] pat;

    assign pat = {m1_i, m2_i, mt_i, s_i};

    always_comb begin
        case (pat)
            {LIGHT_G, LIGHT_G, LIGHT_R, LIGHT_R}: phase_o = PH_1;
            {LIGHT_G, LIGHT_Y, LIGHT_R, LIGHT_R}: phase_o = PH_2;
            {LIGHT_G, LIGHT_R, LIGHT_R, LIGHT_R}: phase_o = PH_3;
            {LIGHT_Y, LIGHT_R, LIGHT_Y, LIGHT_R}: phase_o = PH_4;
            {LIGHT_R, LIGHT_R, LIGHT_Y, LIGHT_G}: phase_o = PH_5;
            {LIGHT_R, LIGHT_R, LIGHT_Y, LIGHT_R}: phase_o = PH_6;
            default:                              phase_o = PH_NONE;
        endcase
    end

endmodule

// File: rtl/tlc_light_monitor.sv
// Conflict/sequence monitor: checks light pattern legality, phase order and dwell,
// latching the first violation as a fault code that drives flash_req.
//
// state | meaning
// SYNC  | waiting for a legal phase transition to lock onto; only illegal patterns fault
// TRACK | locked on; order, dwell and illegal patterns checked every edge
// FAULT | violation latched; checks suspended until fault_clr
module tlc_light_monitor
    import tlc_pkg::*;
#(
    parameter int unsigned ILL_PERSIST = 1,
    parameter logic [7:0]  D1 = DWELL_P1,
    parameter logic [7:0]  D2 = DWELL_P2,
    parameter logic [7:0]  D3 = DWELL_P3,
    parameter logic [7:0]  D4 = DWELL_P4,
    parameter logic [7:0]  D5 = DWELL_P5,
    parameter logic [7:0]  D6 = DWELL_P6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] phase,
    output logic       in_sync,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_req,
    output logic       cycle_done
);

    localparam logic [4:0] ILL_TH = 5'(ILL_PERSIST);

    mon_state_e state_q, state_d;
    logic [2:0] cur;
    logic [2:0] phase_q;
    logic [7:0] dwell_q, dwell_d, dwell_req;
    logic [3:0] ill_q, ill_d;
    logic [2:0] code_q, code_d, evt_code;
    logic       cycle_done_q, cycle_done_d, cycle_evt;
    logic       same, succ, ill_hit;

    tlc_phase_decode u_decode (
        .m1_i    (light_M1),
        .m2_i    (light_M2),
        .mt_i    (light_MT),
        .s_i     (light_S),
        .phase_o (cur)
    );

    always_comb begin
        dwell_d = 8'd1;
        if (cur == phase_q) begin
            dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        end
        ill_d = 4'd0;
        if (cur == PH_NONE) begin
            ill_d = (ill_q == 4'hF) ? ill_q : ill_q + 4'd1;
        end
        case (phase_q)
            PH_1:    dwell_req = D1;
            PH_2:    dwell_req = D2;
            PH_3:    dwell_req = D3;
            PH_4:    dwell_req = D4;
            PH_5:    dwell_req = D5;
            PH_6:    dwell_req = D6;
            default: dwell_req = 8'd0;
        endcase
    end

    assign same    = (cur == phase_q);
    assign succ    = (phase_q != PH_NONE) && (cur == phase_succ(phase_q));
    assign ill_hit = (cur == PH_NONE) && (({1'b0, ill_q} + 5'd1) >= ILL_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MON_SYNC;
            phase_q      <= PH_NONE;
            dwell_q      <= 8'd0;
            ill_q        <= 4'd0;
            code_q       <= FC_NONE;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= cur;
            dwell_q      <= dwell_d;
            ill_q        <= ill_d;
            code_q       <= code_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // A sub-threshold illegal glitch leaves phase at 0 in TRACK; the first legal
    // sample after it re-anchors tracking rather than being judged against "phase 0".
    always_comb begin
        state_d   = state_q;
        evt_code  = FC_NONE;
        cycle_evt = 1'b0;
        case (state_q)
            MON_SYNC: begin
                if (ill_hit) begin
                    evt_code = FC_ILLEGAL;
                end else if (succ) begin
                    state_d = MON_TRACK;
                end
            end
            MON_TRACK: begin
                if (ill_hit) begin
                    evt_code = FC_ILLEGAL;
                end else if (phase_q != PH_NONE) begin
                    if (same) begin
                        if (({1'b0, dwell_q} + 9'd1) > {1'b0, dwell_req}) begin
                            evt_code = FC_OVERSTAY;
                        end
                    end else if (succ) begin
                        if (dwell_q != dwell_req) begin
                            evt_code = FC_SHORT_DWELL;
                        end else if (phase_q == PH_6) begin
                            cycle_evt = 1'b1;
                        end
                    end else if (cur != PH_NONE) begin
                        evt_code = FC_SEQUENCE;
                    end
                end
            end
            MON_FAULT: begin
                if (fault_clr) begin
                    state_d = MON_SYNC;
                end
            end
            default: state_d = MON_SYNC;
        endcase
        if (evt_code != FC_NONE) begin
            state_d = MON_FAULT;
        end
    end

    always_comb begin
        code_d       = code_q;
        cycle_done_d = cycle_evt;
        if (evt_code != FC_NONE) begin
            code_d = evt_code;
        end else if ((state_q == MON_FAULT) && fault_clr) begin
            code_d = FC_NONE;
        end
    end

    assign phase      = phase_q;
    assign in_sync    = (state_q == MON_TRACK);
    assign fault      = (state_q == MON_FAULT);
    assign flash_req  = fault;
    assign fault_code = code_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_tlc_light_monitor.sv
// Directed bench for tlc_light_monitor: two instances (ILL_PERSIST 1 and 2) share stimulus.
// Expected values are hand-derived from the phase table and default dwells 8/3/6/6/4/3.
module tb_tlc_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault_clr = 1'b0;

    logic [2:0] phase1, code1, phase2, code2;
    logic       sync1, fault1, flash1, cd1;
    logic       sync2, fault2, flash2, cd2;

    int total = 0;
    int bad = 0;
    int dw [7] = '{0, 8, 3, 6, 6, 4, 3};

    always #5 clk = ~clk;

    tlc_light_monitor #(.ILL_PERSIST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .fault_clr(fault_clr),
        .phase(phase1), .in_sync(sync1), .fault(fault1), .fault_code(code1),
        .flash_req(flash1), .cycle_done(cd1)
    );

    tlc_light_monitor #(.ILL_PERSIST(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .fault_clr(fault_clr),
        .phase(phase2), .in_sync(sync2), .fault(fault2), .fault_code(code2),
        .flash_req(flash2), .cycle_done(cd2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ph(input int p);
        case (p)
            1:       {light_M1, light_M2, light_MT, light_S} = {G, G, R, R};
            2:       {light_M1, light_M2, light_MT, light_S} = {G, Y, R, R};
            3:       {light_M1, light_M2, light_MT, light_S} = {G, R, R, R};
            4:       {light_M1, light_M2, light_MT, light_S} = {Y, R, Y, R};
            5:       {light_M1, light_M2, light_MT, light_S} = {R, R, Y, G};
            6:       {light_M1, light_M2, light_MT, light_S} = {R, R, Y, R};
            default: {light_M1, light_M2, light_MT, light_S} = {R, R, R, R};
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            set_ph(p);
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, int'(phase1), 0);
        chk({tag, "_sync"}, int'(sync1), 0);
        chk({tag, "_fault"}, int'(fault1), 0);
        chk({tag, "_code"}, int'(code1), 0);
        chk({tag, "_flash"}, int'(flash1), 0);
        chk({tag, "_cd"}, int'(cd1), 0);
        chk({tag, "_phase2"}, int'(phase2), 0);
        chk({tag, "_sync2"}, int'(sync2), 0);
        chk({tag, "_fault2"}, int'(fault2), 0);
    endtask

    task automatic do_clear(input int p);
        fault_clr = 1'b1;
        set_ph(p);
        tick();
        fault_clr = 1'b0;
    endtask

    initial begin
        logic synced;
        int   prev;
        int   exp_pulses;
        int   act_pulses;
        int   exp_cd;

        set_ph(1);
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Nominal three cycles starting from P1
        synced = 1'b0;
        prev = 0;
        exp_pulses = 0;
        act_pulses = 0;
        for (int c = 0; c < 3; c++) begin
            for (int p = 1; p <= 6; p++) begin
                for (int n = 0; n < dw[p]; n++) begin
                    set_ph(p);
                    tick();
                    exp_cd = (synced && prev == 6 && p == 1) ? 1 : 0;
                    if (prev == 1 && p == 2) synced = 1'b1;
                    chk("nom_phase", int'(phase1), p);
                    chk("nom_sync", int'(sync1), int'(synced));
                    chk("nom_cd", int'(cd1), exp_cd);
                    chk("nom_fault", int'(fault1), 0);
                    chk("nom_fault2", int'(fault2), 0);
                    if (cd1) act_pulses++;
                    exp_pulses += exp_cd;
                    prev = p;
                end
            end
        end
        chk("nom_pulses", act_pulses, 2);
        chk("nom_pulses_model", act_pulses, exp_pulses);

        // Overstay in P3
        hold(1, 1);
        chk("wrap_cd", int'(cd1), 1);
        hold(1, 7);
        chk("wrap_cd_off", int'(cd1), 0);
        hold(2, 3);
        hold(3, 6);
        chk("p3_6_fault", int'(fault1), 0);
        hold(3, 1);
        chk("over_fault", int'(fault1), 1);
        chk("over_code", int'(code1), 4);
        chk("over_flash", int'(flash1), 1);
        chk("over_sync", int'(sync1), 0);
        chk("over_code2", int'(code2), 4);
        hold(4, 1);
        chk("fault_holds_code", int'(code1), 4);
        chk("fault_phase_upd", int'(phase1), 4);

        // Clear and resync, then short dwell in P5
        do_clear(4);
        chk("clr_fault", int'(fault1), 0);
        chk("clr_code", int'(code1), 0);
        chk("clr_sync", int'(sync1), 0);
        hold(5, 1);
        chk("resync", int'(sync1), 1);
        hold(5, 2);
        chk("p5_3_fault", int'(fault1), 0);
        hold(6, 1);
        chk("short_fault", int'(fault1), 1);
        chk("short_code", int'(code1), 3);

        // Bad sequence P1->P3
        do_clear(6);
        hold(1, 1);
        chk("sync_p1", int'(sync1), 1);
        chk("sync_p1_cd", int'(cd1), 0);
        hold(1, 7);
        hold(3, 1);
        chk("seq13_code", int'(code1), 2);
        chk("seq13_flash", int'(flash1), 1);

        // Bad sequence P4->P6
        do_clear(3);
        hold(4, 3);
        chk("p4_sync", int'(sync1), 1);
        hold(6, 1);
        chk("seq46_code", int'(code1), 2);

        // One-cycle illegal glitch on M1
        do_clear(6);
        hold(1, 3);
        chk("pre_ill_sync", int'(sync1), 1);
        {light_M1, light_M2, light_MT, light_S} = {3'b011, G, R, R};
        tick();
        chk("ill_code", int'(code1), 1);
        chk("ill_fault", int'(fault1), 1);
        chk("ill_phase", int'(phase1), 0);
        chk("ill2_fault", int'(fault2), 0);
        chk("ill2_sync", int'(sync2), 1);
        chk("ill2_phase", int'(phase2), 0);
        hold(1, 1);
        chk("ill2_ret_fault", int'(fault2), 0);
        chk("ill2_ret_sync", int'(sync2), 1);
        chk("ill2_ret_phase", int'(phase2), 1);
        do_clear(1);
        chk("clr_dut1", int'(fault1), 0);
        chk("clr_noeffect_sync2", int'(sync2), 1);
        chk("clr_noeffect_fault2", int'(fault2), 0);
        hold(1, 6);
        hold(2, 1);
        chk("dut1_resync", int'(sync1), 1);
        chk("dut2_p12_ok", int'(fault2), 0);
        hold(2, 2);
        hold(3, 6);
        hold(4, 2);
        chk("pre_rst_sync", int'(sync1), 1);
        chk("pre_rst_phase", int'(phase1), 4);

        // Asynchronous reset mid-P4
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        hold(4, 1);
        chk("post_rst_sync", int'(sync1), 0);
        chk("post_rst_phase", int'(phase1), 4);
        hold(5, 1);
        chk("post_rst_resync", int'(sync1), 1);
        chk("post_rst_fault", int'(fault1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
